// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM encoding, requester identities and default widths
// for the two-port instruction/data memory arbiter.
package mem_arbiter_pkg;
    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_t;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; a lone requester always wins,
// a contested pick goes to the port that did not win last.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    output port_t      grant
);
    always_comb begin
        grant = (&req) ? port_t'(~last) : port_t'(req[1]);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory between a fetch port and a data
// port; each access runs IDLE -> ACCESS -> RESP, so one access per 3 cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-2:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    state_t        r_state, w_next;
    port_t         r_id, r_last, w_grant;
    logic          r_we, r_mis, w_resp, w_take, w_is_d;
    logic [AW-2:0] r_addr;
    logic [DW-1:0] r_wdata, r_i_rdata, r_d_rdata, w_rdata;

    rr_arb2 u_rr (
        .req   ({d_req, i_req}),
        .last  (r_last),
        .grant (w_grant)
    );

    always_comb begin
        w_take    = (r_state == S_IDLE) && (i_req || d_req);
        w_is_d    = (w_grant == PORT_D);
        w_next    = w_take ? S_ACCESS : (r_state == S_ACCESS) ? S_RESP : S_IDLE;
        w_resp    = (r_state == S_RESP);
        w_rdata   = r_mis ? '0 : mem_rdata;
        mem_en    = (r_state == S_ACCESS) && !r_mis;
        mem_we    = mem_en && r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        i_ack     = w_resp && (r_id == PORT_I);
        d_ack     = w_resp && (r_id == PORT_D);
        err       = w_resp && r_mis;
        i_rdata   = i_ack ? w_rdata : r_i_rdata;
        d_rdata   = d_ack ? w_rdata : r_d_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_id      <= PORT_I;
            r_last    <= PORT_I;
            r_we      <= 1'b0;
            r_mis     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_id    <= w_grant;
                r_last  <= w_grant;
                r_we    <= w_is_d && d_we;
                r_mis   <= w_is_d ? d_addr[0] : i_addr[0];
                r_addr  <= w_is_d ? d_addr[AW-1:1] : i_addr[AW-1:1];
                r_wdata <= w_is_d ? d_wdata : '0;
            end
            // Latched so the idle port's rdata keeps showing its last result.
            if (i_ack) r_i_rdata <= w_rdata;
            if (d_ack) r_d_rdata <= w_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table for single accesses plus hand-written
// contention and reset-abort sequences against a simple synchronous memory.
module tb_mem_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack, err, mem_en, mem_we;
    logic [15:0] i_rdata, d_rdata, mem_wdata, mem_rdata = '0;
    logic [14:0] mem_addr;
    logic [15:0] mem [0:32767];
    int          n_pass = 0, n_tot = 0;

    typedef struct {
        logic        d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_en;
        logic        exp_err;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] hold_i = '0, hold_d = '0;
    logic        hv_i = 1'b1, hv_d = 1'b1;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else mem_rdata <= mem[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (i_ack && d_ack) $error("FAIL assert_dual_ack");
        if (mem_we && !mem_en) $error("FAIL assert_we_without_en");
        if (mem_we && !d_req) $error("FAIL assert_fetch_write");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        i_req = !v.d; i_addr = v.addr;
        d_req = v.d; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d mem_en", k), 32'(mem_en), 32'(v.exp_en));
        chk($sformatf("v%0d mem_we", k), 32'(mem_we), 32'(v.we & v.exp_en));
        if (v.exp_en) chk($sformatf("v%0d mem_addr", k), 32'(mem_addr), 32'(v.addr[15:1]));
        if (v.exp_en && v.we) chk($sformatf("v%0d mem_wdata", k), 32'(mem_wdata), 32'(v.wdata));
        chk($sformatf("v%0d early_ack", k), 32'(i_ack | d_ack), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d ack", k), 32'(v.d ? d_ack : i_ack), 32'd1);
        chk($sformatf("v%0d other_ack", k), 32'(v.d ? i_ack : d_ack), 32'd0);
        chk($sformatf("v%0d err", k), 32'(err), 32'(v.exp_err));
        if (v.chk_rd) chk($sformatf("v%0d rdata", k), 32'(v.d ? d_rdata : i_rdata), 32'(v.exp_rd));
        if (v.d && hv_i) chk($sformatf("v%0d i_hold", k), 32'(i_rdata), 32'(hold_i));
        if (!v.d && hv_d) chk($sformatf("v%0d d_hold", k), 32'(d_rdata), 32'(hold_d));
        if (v.d) begin hold_d = v.exp_rd; hv_d = v.chk_rd; end
        else begin hold_i = v.exp_rd; hv_i = v.chk_rd; end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   n;
        logic seq [4];
        int   cyc [4];
        mem[15'h0008] = 16'hA5C3;
        //        d     we    addr      wdata     en    err   chk   rdata
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA5C3};
        vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[3] = '{1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{1'b1, 1'b1, 16'hFFFE, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hBEEF};
        vecs[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA5C3};
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst mem_en", 32'(mem_en), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst acks_err", 32'({i_ack, d_ack, err}), 32'd0);
        chk("rst rdata", {i_rdata, d_rdata}, 32'd0);
        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Contention straight after reset: D first, then alternate every 3 cycles.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        i_req = 1'b1; i_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        n = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if ((i_ack || d_ack) && n < 4) begin
                seq[n] = d_ack;
                cyc[n] = c;
                chk($sformatf("cont%0d rdata", n), 32'(d_ack ? d_rdata : i_rdata),
                    32'(d_ack ? 16'h1234 : 16'hA5C3));
                n++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("cont ack_count", 32'(n), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("cont%0d port", j), 32'(j < n ? seq[j] : 1'bx), 32'((j % 2) == 0));
            chk($sformatf("cont%0d cycle", j), 32'(j < n ? cyc[j] : -1), 32'(2 + 3 * j));
        end
        @(negedge clk);

        // Reset landing in ACCESS abandons the load; the reissue completes.
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clk);
        chk("abort mem_en_before", 32'(mem_en), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort acks", 32'({i_ack, d_ack, err}), 32'd0);
        chk("abort mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        chk("reissue mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        chk("reissue d_ack", 32'(d_ack), 32'd1);
        chk("reissue d_rdata", 32'(d_rdata), 32'h1234);
        d_req = 1'b0;
        @(negedge clk);
        chk("reissue idle_ack", 32'(d_ack), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
